mdu_sched: RTL and testbench
============================

MDU_SCHED -- requirements
Module: mdu_sched

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, E-stage multiply/divide or MT-class instruction valid this cycle.
REQ-004 SHALL have port mdu_op, input, 4, operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO; other codes are NOP.
REQ-005 SHALL have port flush, input, 1, exception/interrupt cancel of the E-stage instruction this cycle.
REQ-006 SHALL have port src_a, input, 32, rs operand.
REQ-007 SHALL have port src_b, input, 32, rt operand.
REQ-008 SHALL have port busy, output, 1, multi-cycle operation in progress.
REQ-009 SHALL have port stall, output, 1, pipeline must hold E stage.
REQ-010 SHALL have port rd_data, output, 32, MFHI/MFLO result.
REQ-011 SHALL have ports hi and lo, output, 32 each, architectural HI/LO.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, with a 4-bit cycle counter.
REQ-013 Accept condition SHALL be start & ~flush & (state==IDLE).
- MULT/MULTU/DIV/DIVU accept: compute result at accept edge into pending_hi/pending_lo; load counter.
REQ-014 MULT/MULTU: IDLE->MUL, counter=5; busy high exactly 5 cycles after the accept edge.
REQ-015 DIV/DIVU: IDLE->DIV, counter=10; busy high exactly 10 cycles.
REQ-016 Counter SHALL decrement each cycle in MUL/DIV; at the edge where it reaches 0, hi/lo take pending values and state returns to IDLE in the same edge.
- busy drops and the new hi/lo become visible together.
REQ-017 MULT SHALL be signed 32x32->64; MULTU unsigned; hi=upper 32 bits, lo=lower 32 bits.
REQ-018 DIV SHALL give lo=signed quotient truncated toward zero, hi=remainder with the sign of the dividend; DIVU unsigned.
- Signed 0x80000000/-1: lo=0x80000000, hi=0.
REQ-019 MTHI/MTLO accept SHALL write src_a to hi/lo at the accept edge, with no busy.
REQ-020 rd_data SHALL be combinational: hi for MFHI, lo for MFLO, 0 otherwise.
REQ-021 stall SHALL be combinational: start & busy & (mdu_op is any defined op).
- Also asserted in the accept cycle's successor only via busy.
REQ-022 start while busy SHALL be ignored; the in-flight operation is unaffected.
REQ-023 flush SHALL block acceptance in that cycle only.
- flush during MUL/DIV SHALL NOT abort the operation; it completes and commits.
REQ-024 start with an undefined op SHALL change no state.

Reset
REQ-025 reset SHALL force state=IDLE, counter=0, and hi, lo, pending_hi, pending_lo=0.
- Resulting outputs: busy=0, stall=0.
REQ-026 reset SHALL take priority over start and over in-flight completion.
- Reset mid-operation discards the pending result.

Configuration
REQ-027 Macro MDU_DIV_ZERO_HOLD_EN SHALL control divide-by-zero handling.
- Defined: DIV/DIVU with src_b=0 still takes 10 busy cycles, then leaves hi/lo unchanged.
- Undefined: result lo=0xFFFFFFFF, hi=src_a.

Structure
REQ-028 The mdu_op encodings and the latency constants (5, 10) SHALL live in the shared constants file alongside the ALU op codes.
REQ-029 Combinational product/quotient logic SHALL be a sub-module mdu_arith (inputs op, a, b; outputs res_hi, res_lo); mdu_sched holds the FSM, counter and registers.

Verification
REQ-030 MULT a=0xFFFFFFFE, b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU same operands -> lo=0x7FFFFFFC, hi=1.
REQ-032 MULTU in flight, then start MFHI on cycle 2 -> stall=1 until busy drops; rd_data=new hi on the release cycle.
REQ-033 start=1 with flush=1, MTLO a=0x1234 -> lo unchanged, busy=0; the same stimulus without flush gives lo=0x1234 the next cycle.
REQ-034 reset asserted in DIV cycle 4 -> next cycle busy=0, hi=lo=0, state IDLE.
REQ-035 DIV b=0, a=0x55 -> after 10 cycles hi/lo unchanged with the macro defined; lo=0xFFFFFFFF, hi=0x55 without it.

Source files
------------

// File: rtl/mdu_sched_pkg.sv
// mdu_sched_pkg -- shared constants for the execute stage.
// Holds the ALU op codes, the multiply/divide unit op encodings, the
// multi-cycle latencies and the scheduler state type.
// Optional feature macro used by mdu_sched: MDU_DIV_ZERO_HOLD_EN.
package mdu_sched_pkg;

    // ALU op codes, kept here so all execute-stage encodings live together.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    // Multiply/divide unit op codes; 0 and 9..15 are NOP.
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    // Busy cycles after the accept edge.
    localparam logic [3:0] MUL_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    function automatic logic mdu_op_defined(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_MFLO);
    endfunction

endpackage

// File: rtl/mdu_sched_arith.sv
// mdu_arith -- combinational product / quotient for the MDU.
// Ports: op (MDU op code), a/b (rs/rt operands),
//        res_hi/res_lo (HI/LO result for MULT*/DIV*, 0 for other ops).
// Divide by zero yields lo=all ones, hi=a; the scheduler decides whether
// that result is committed.
module mdu_arith
    import mdu_sched_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic        w_signed;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [63:0] w_prod;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_q;
    logic [31:0] w_r;

    always_comb begin
        w_signed = (op == OP_MULT) || (op == OP_DIV);
        w_neg_a  = w_signed & a[31];
        w_neg_b  = w_signed & b[31];
        // Sign-extending to 64 bits lets one 64-bit multiply cover both forms.
        w_prod   = {{32{w_neg_a}}, a} * {{32{w_neg_b}}, b};
        // Signed divide is done on magnitudes; |0x80000000| is still 2^31
        // as unsigned, so 0x80000000 / -1 falls out as 0x80000000 rem 0.
        w_abs_a  = w_neg_a ? (32'd0 - a) : a;
        w_abs_b  = w_neg_b ? (32'd0 - b) : b;
        w_q      = '1;
        w_r      = a;
        if (b != 32'd0) begin
            w_q = w_abs_a / w_abs_b;
            w_r = w_abs_a % w_abs_b;
        end

        res_hi = 32'd0;
        res_lo = 32'd0;
        if ((op == OP_MULT) || (op == OP_MULTU)) begin
            res_hi = w_prod[63:32];
            res_lo = w_prod[31:0];
        end else if ((op == OP_DIV) || (op == OP_DIVU)) begin
            if (b == 32'd0) begin
                res_hi = a;
                res_lo = '1;
            end else begin
                res_lo = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q) : w_q;
                res_hi = w_neg_a ? (32'd0 - w_r) : w_r;
            end
        end
    end

endmodule

// File: rtl/mdu_sched.sv
// mdu_sched -- multiply/divide scheduler with architectural HI/LO.
// Ports: clk, reset (sync, active high), start/mdu_op/flush (E-stage
//        request), src_a/src_b (operands), busy, stall, rd_data (MFHI/MFLO
//        read), hi/lo (architectural registers).
// MULT* hold busy 5 cycles, DIV* 10 cycles; the result is computed at the
// accept edge and committed to hi/lo at the edge that ends busy.
// Macro MDU_DIV_ZERO_HOLD_EN: when defined, divide by zero still takes the
// full latency but leaves hi/lo unchanged.
module mdu_sched
    import mdu_sched_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic        flush,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
`ifdef MDU_DIV_ZERO_HOLD_EN
    logic        r_pend_hold;
`endif

    logic        w_accept;
    logic        w_is_mul;
    logic        w_is_div;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    mdu_arith u_arith (
        .op     (mdu_op),
        .a      (src_a),
        .b      (src_b),
        .res_hi (w_res_hi),
        .res_lo (w_res_lo)
    );

    assign w_accept = start & ~flush & (r_state == ST_IDLE);
    assign w_is_mul = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
    assign w_is_div = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);

    assign busy    = (r_state != ST_IDLE);
    assign stall   = start & busy & mdu_op_defined(mdu_op);
    assign rd_data = (mdu_op == OP_MFHI) ? r_hi :
                     (mdu_op == OP_MFLO) ? r_lo : 32'd0;
    assign hi      = r_hi;
    assign lo      = r_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_pend_hi   <= 32'd0;
            r_pend_lo   <= 32'd0;
`ifdef MDU_DIV_ZERO_HOLD_EN
            r_pend_hold <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul || w_is_div) begin
                            r_state   <= w_is_mul ? ST_MUL : ST_DIV;
                            r_cnt     <= w_is_mul ? MUL_LAT : DIV_LAT;
                            r_pend_hi <= w_res_hi;
                            r_pend_lo <= w_res_lo;
`ifdef MDU_DIV_ZERO_HOLD_EN
                            r_pend_hold <= w_is_div && (src_b == 32'd0);
`endif
                        end else if (mdu_op == OP_MTHI) begin
                            r_hi <= src_a;
                        end else if (mdu_op == OP_MTLO) begin
                            r_lo <= src_a;
                        end
                    end
                end
                default: begin
                    // Requests (and flush) are ignored while in flight.
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
`ifdef MDU_DIV_ZERO_HOLD_EN
                        if (!r_pend_hold) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
`else
                        r_hi <= r_pend_hi;
                        r_lo <= r_pend_lo;
`endif
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sched.sv
module tb_mdu_sched;

    localparam logic [3:0] MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7, MFLO = 4'd8;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [3:0]  mdu_op;
    logic [31:0] src_a, src_b;
    logic        busy, stall;
    logic [31:0] rd_data, hi, lo;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural HI/LO, the result waiting to land,
    // and how many busy cycles remain.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    bit          m_phold;
    int          m_left;

    always #5 clk = ~clk;

    mdu_sched dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mdu_op  (mdu_op),
        .flush   (flush),
        .src_a   (src_a),
        .src_b   (src_b),
        .busy    (busy),
        .stall   (stall),
        .rd_data (rd_data),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit defined_op(input logic [3:0] op);
        return op inside {MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO};
    endfunction

    task automatic check_all(input string tag);
        logic        e_busy;
        logic [31:0] e_rd;
        e_busy = (m_left > 0);
        e_rd   = (mdu_op == MFHI) ? m_hi : (mdu_op == MFLO) ? m_lo : 32'd0;
        chk({tag, ".busy"},  {31'd0, busy},  {31'd0, e_busy});
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, start & e_busy & defined_op(mdu_op)});
        chk({tag, ".rd"},    rd_data, e_rd);
        chk({tag, ".hi"},    hi, m_hi);
        chk({tag, ".lo"},    lo, m_lo);
    endtask

    // Architectural effect of one clock edge given this cycle's inputs.
    task automatic model_edge(input bit rst, input bit st, input logic [3:0] op,
                              input bit fl, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        if (rst) begin
            m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_phold = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && !m_phold) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (st && !fl) begin
            if (op == MULT || op == DIV) begin
                sa = $signed(a); sb = $signed(b);
            end else begin
                sa = {32'd0, a}; sb = {32'd0, b};
            end
            m_phold = 0;
            case (op)
                MULT, MULTU: begin
                    p = sa * sb;
                    m_phi = p[63:32]; m_plo = p[31:0];
                    m_left = 5;
                end
                DIV, DIVU: begin
                    m_left = 10;
                    if (b == 0) begin
`ifdef MDU_DIV_ZERO_HOLD_EN
                        m_phold = 1;
`else
                        m_phi = a; m_plo = 32'hFFFF_FFFF;
`endif
                    end else begin
                        q = sa / sb; r = sa % sb;
                        m_plo = q[31:0]; m_phi = r[31:0];
                    end
                end
                MTHI: m_hi = a;
                MTLO: m_lo = a;
                default: ;
            endcase
        end
    endtask

    // One cycle: drive, check the settled outputs, then step the clock.
    task automatic cyc(input string tag, input bit rst, input bit st, input logic [3:0] op,
                       input bit fl, input logic [31:0] a, input logic [31:0] b);
        reset = rst; start = st; mdu_op = op; flush = fl; src_a = a; src_b = b;
        #1;
        if (!rst) check_all(tag);
        @(posedge clk);
        model_edge(rst, st, op, fl, a, b);
        #1;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 0, 0, 4'd0, 0, 32'd0, 32'd0);
    endtask

    logic [31:0] specials [0:4];

    initial begin
        specials[0] = 32'd0;          specials[1] = 32'h8000_0000;
        specials[2] = 32'hFFFF_FFFF;  specials[3] = 32'd1;
        specials[4] = 32'h7FFF_FFFF;

        // Reset
        reset = 1; start = 0; mdu_op = 0; flush = 0; src_a = 0; src_b = 0;
        @(posedge clk); @(posedge clk); #1;
        model_edge(1, 0, 0, 0, 0, 0);
        check_all("reset");

        // Signed multiply
        cyc("mult_acc", 0, 1, MULT, 0, 32'hFFFF_FFFE, 32'd3);
        idle("mult_busy", 5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        chk("mult_done", {31'd0, busy}, 32'd0);

        // Signed and unsigned divide
        cyc("div_acc", 0, 1, DIV, 0, 32'hFFFF_FFF9, 32'd2);
        idle("div_busy", 10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        cyc("divu_acc", 0, 1, DIVU, 0, 32'hFFFF_FFF9, 32'd2);
        idle("divu_busy", 10);
        chk("divu_lo", lo, 32'h7FFF_FFFC);
        chk("divu_hi", hi, 32'd1);

        // Overflow case
        cyc("ovf_acc", 0, 1, DIV, 0, 32'h8000_0000, 32'hFFFF_FFFF);
        idle("ovf_busy", 10);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);

        // MFHI behind an in-flight MULTU stalls until the release cycle
        cyc("mfhi_acc", 0, 1, MULTU, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle("mfhi_c1", 1);
        while (m_left > 0) cyc("mfhi_stall", 0, 1, MFHI, 0, 32'd0, 32'd0);
        start = 1; mdu_op = MFHI; #1;
        chk("mfhi_rel_rd", rd_data, 32'hFFFF_FFFE);
        chk("mfhi_rel_stall", {31'd0, stall}, 32'd0);
        cyc("mfhi_rel", 0, 1, MFHI, 0, 32'd0, 32'd0);

        // Flushed MTLO does nothing; unflushed one writes
        cyc("mtlo_fl", 0, 1, MTLO, 1, 32'h1234, 32'd0);
        chk("mtlo_fl_lo", lo, 32'h0000_0001);
        chk("mtlo_fl_busy", {31'd0, busy}, 32'd0);
        cyc("mtlo", 0, 1, MTLO, 0, 32'h1234, 32'd0);
        chk("mtlo_lo", lo, 32'h1234);

        // Flush during DIV does not abort it
        cyc("dfl_acc", 0, 1, DIV, 0, 32'd100, 32'd7);
        cyc("dfl_flush", 0, 1, DIV, 1, 32'd5, 32'd5);
        idle("dfl_busy", 9);
        chk("dfl_lo", lo, 32'd14);
        chk("dfl_hi", hi, 32'd2);

        // Reset in DIV cycle 4 discards the result
        cyc("rdiv_acc", 0, 1, DIV, 0, 32'd77, 32'd3);
        idle("rdiv_busy", 3);
        cyc("rdiv_rst", 1, 0, 4'd0, 0, 32'd0, 32'd0);
        chk("rdiv_busy0", {31'd0, busy}, 32'd0);
        chk("rdiv_hi0", hi, 32'd0);
        chk("rdiv_lo0", lo, 32'd0);
        idle("rdiv_after", 12);

        // Divide by zero
        cyc("dz_mthi", 0, 1, MTHI, 0, 32'hAAAA, 32'd0);
        cyc("dz_mtlo", 0, 1, MTLO, 0, 32'hBBBB, 32'd0);
        cyc("dz_acc", 0, 1, DIV, 0, 32'h55, 32'd0);
        idle("dz_busy", 10);
`ifdef MDU_DIV_ZERO_HOLD_EN
        chk("dz_hi", hi, 32'hAAAA);
        chk("dz_lo", lo, 32'hBBBB);
`else
        chk("dz_hi", hi, 32'h55);
        chk("dz_lo", lo, 32'hFFFF_FFFF);
`endif

        // Undefined op changes nothing
        cyc("nop", 0, 1, 4'd12, 0, 32'hDEAD, 32'hBEEF);
        idle("nop_after", 1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 1) == 0) b = b >> $urandom_range(0, 31);
            cyc("rnd", ($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
                4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0), a, b);
        end
        idle("rnd_tail", 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
